pixel_readout_tx: RTL and testbench

PIXEL_READOUT_TX -- requirements
Module: pixel_readout_tx

---
 rtl/pixel_readout_tx_if.sv | 23 ++
 rtl/pixel_readout_tx.sv | 181 ++++++++++++++++++
 tb/tb_pixel_readout_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_tx_if.sv
// Pixel SRAM read port and MCU SPI slave pins of pixel_readout_tx.
// master = the readout block, slave = SRAM + MCU side.
interface pixel_readout_tx_if #(
    parameter int RGB_SIZE = 8
);
    logic [15:0]         sram_addr;
    logic                sram_rden;
    logic [RGB_SIZE-1:0] sram_q;
    logic                spi_sclk;
    logic                spi_cs_n;
    logic                spi_miso;
    logic                MCU_RX_RDY;

    modport master (
        output sram_addr, sram_rden, spi_miso, MCU_RX_RDY,
        input  sram_q, spi_sclk, spi_cs_n
    );

    modport slave (
        input  sram_addr, sram_rden, spi_miso, MCU_RX_RDY,
        output sram_q, spi_sclk, spi_cs_n
    );
endinterface

// File: rtl/pixel_readout_tx.sv
// Frame readout: pixel SRAM -> output bytes -> SPI mode-0 slave clocked by the MCU.
// Build option PIXEL_PACK_EN: pack 8 thresholded pixels per byte; undefined sends raw pixels.
module pixel_readout_tx #(
    parameter int IMAGEX      = 64,
    parameter int IMAGEY      = 64,
    parameter int IMAGE_SIZE  = IMAGEX * IMAGEY,
    parameter int RGB_SIZE    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    pixel_readout_tx_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PACK, STAGE, FINISH} state_t;

    state_t      state, state_next;
    logic [15:0] pixel_idx;
    logic [7:0]  pack_byte;
    logic        last_pix;
    logic        byte_done;
    logic        stage_load;
    logic        rden;
    logic        done_c;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic sclk_prev, cs_prev, sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [7:0] stage_buf, tx_byte, shift_reg;
    logic       stage_full, in_byte, tx_real;
    logic [3:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_rise = ~sclk_prev & sclk_s & ~cs_s;
    assign sclk_fall = sclk_prev & ~sclk_s & ~cs_s;

    // A byte slot opens on cs_n fall or on the 8th falling edge; an empty slot shifts zeros.
    // underrun is flagged once the MCU actually clocks such a byte, so the trailing 8th
    // falling edge of a frame's last byte does not count as a started byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_buf  <= '0;
            stage_full <= 1'b0;
            tx_byte    <= '0;
            shift_reg  <= '0;
            tx_real    <= 1'b0;
            in_byte    <= 1'b0;
            bit_cnt    <= '0;
            underrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge register values.
            if (stage_load) begin
                stage_buf  <= pack_byte;
                stage_full <= 1'b1;
            end
            if (cs_fall && in_byte) begin
                shift_reg <= tx_byte;
                bit_cnt   <= '0;
            end else if (cs_fall || (sclk_fall && bit_cnt == 4'd8)) begin
                bit_cnt <= '0;
                in_byte <= 1'b1;
                if (stage_full) begin
                    shift_reg  <= stage_buf;
                    tx_byte    <= stage_buf;
                    tx_real    <= 1'b1;
                    stage_full <= 1'b0;
                end else begin
                    shift_reg <= '0;
                    tx_byte   <= '0;
                    tx_real   <= 1'b0;
                end
            end else if (cs_rise) begin
                bit_cnt <= '0;
                if (!tx_real) in_byte <= 1'b0;
            end else if (sclk_rise && in_byte) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (!tx_real) underrun <= 1'b1;
                if (bit_cnt == 4'd7) in_byte <= 1'b0;
            end else if (sclk_fall && in_byte) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

    assign bus.spi_miso   = ~bus.spi_cs_n & ~cs_s & shift_reg[7];
    assign bus.MCU_RX_RDY = stage_full;

`ifdef PIXEL_PACK_EN
    assign byte_done = (pixel_idx[2:0] == 3'd0);
`else
    assign byte_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_next = state;
        stage_load = 1'b0;
        rden       = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE:   if (start) state_next = FETCH;
            FETCH: begin
                rden       = 1'b1;
                state_next = WAIT;
            end
            WAIT:   state_next = PACK;
            PACK: begin
                if (!byte_done)       state_next = FETCH;
                else if (!stage_full) state_next = STAGE;
            end
            STAGE: begin
                stage_load = 1'b1;
                state_next = last_pix ? FINISH : FETCH;
            end
            FINISH: begin
                if (!stage_full && !(in_byte && tx_real)) begin
                    done_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_idx <= '0;
            pack_byte <= '0;
            last_pix  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                pixel_idx <= '0;
                last_pix  <= 1'b0;
            end
            if (state == WAIT) begin
`ifdef PIXEL_PACK_EN
                pack_byte <= {pack_byte[6:0], (int'(bus.sram_q) >= 128)};
`else
                pack_byte <= 8'(bus.sram_q);
`endif
                if (pixel_idx == 16'(IMAGE_SIZE - 1)) begin
                    pixel_idx <= '0;
                    last_pix  <= 1'b1;
                end else begin
                    pixel_idx <= pixel_idx + 16'd1;
                end
            end
        end
    end

    assign bus.sram_addr = pixel_idx;
    assign bus.sram_rden = rden;
    assign busy          = (state != IDLE);
    assign done          = done_c;
endmodule

// File: tb/tb_pixel_readout_tx.sv
// Scoreboard bench for pixel_readout_tx: an MCU SPI model clocks bytes out at clk/8,
// a monitor compares each received byte against the queue filled by the stimulus.
module tb_pixel_readout_tx;
    localparam int IMAGEX     = 16;
    localparam int IMAGEY     = 8;
    localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
    localparam int RGB_SIZE   = 8;
`ifdef PIXEL_PACK_EN
    localparam int BYTES = IMAGE_SIZE / 8;
`else
    localparam int BYTES = IMAGE_SIZE;
`endif
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, underrun;

    pixel_readout_tx_if #(.RGB_SIZE(RGB_SIZE)) bus ();

    pixel_readout_tx #(
        .IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .IMAGE_SIZE(IMAGE_SIZE),
        .RGB_SIZE(RGB_SIZE), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .underrun(underrun),
        .bus(bus)
    );

    always #10 clk = ~clk;

    logic [7:0] mem [IMAGE_SIZE];
    always @(posedge clk) if (bus.sram_rden) bus.sram_q <= mem[int'(bus.sram_addr)];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_bytes [BYTES];
    logic [7:0] rx_byte;
    event       rx_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(rx_ev);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got 0x%02h expected no byte", rx_byte);
        end else begin
            check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        clk_wait(1);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.MCU_RX_RDY && t < 500) begin
            clk_wait(1);
            t++;
        end
        check("rdy_timeout", 32'(bus.MCU_RX_RDY), 32'd1);
    endtask

    task automatic spi_bit();
        bus.spi_sclk = 1'b1;
        clk_wait(HALF);
        bus.spi_sclk = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic spi_byte();
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) begin
            b[i] = bus.spi_miso;
            spi_bit();
        end
        rx_byte = b;
        -> rx_ev;
    endtask

    task automatic spi_frame(input int n, input bit wait_rdy);
        if (wait_rdy) wait_ready();
        bus.spi_cs_n = 1'b0;
        clk_wait(2 * HALF);
        for (int k = 0; k < n; k++) spi_byte();
        bus.spi_cs_n = 1'b1;
        clk_wait(2 * HALF);
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 400) begin
            clk_wait(1);
            t++;
        end
        clk_wait(20);
        check("done_count", 32'(done_cnt), 32'(target));
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic push_expected(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_bytes[k]);
    endtask

    // Pack: alternating 0xFF/0x00 pixels -> every byte 0xAA. Raw: byte k = k mod 256.
    task automatic load_pattern_a();
        for (int i = 0; i < IMAGE_SIZE; i++) begin
`ifdef PIXEL_PACK_EN
            mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
`else
            mem[i] = 8'(i);
`endif
        end
        for (int k = 0; k < BYTES; k++) begin
`ifdef PIXEL_PACK_EN
            exp_bytes[k] = 8'hAA;
`else
            exp_bytes[k] = 8'(k);
`endif
        end
    endtask

    // Byte 0 = 0x5A, byte 1 = 0xC3; packed pixels sit right at the 0x80/0x7F threshold.
    task automatic load_pattern_b();
        logic [7:0] b;
        for (int k = 0; k < BYTES; k++) begin
            if (k == 0)      b = 8'h5A;
            else if (k == 1) b = 8'hC3;
            else             b = 8'(k * 7) ^ 8'h11;
            exp_bytes[k] = b;
`ifdef PIXEL_PACK_EN
            for (int j = 0; j < 8; j++) mem[8 * k + j] = b[7 - j] ? 8'h80 : 8'h7F;
`else
            mem[k] = b;
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_addr"},  32'(bus.sram_addr),  32'd0);
        check({tag, "_sram_rden"},  32'(bus.sram_rden),  32'd0);
        check({tag, "_spi_miso"},   32'(bus.spi_miso),   32'd0);
        check({tag, "_mcu_rx_rdy"}, 32'(bus.MCU_RX_RDY), 32'd0);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_done"},       32'(done),           32'd0);
        check({tag, "_underrun"},   32'(underrun),       32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        load_pattern_a();
        clk_wait(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        clk_wait(3);

        // MCU clocks two bytes with nothing staged
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        spi_frame(2, 1'b0);
        check("underrun_set", 32'(underrun), 32'd1);
        clk_wait(50);
        check("underrun_sticky", 32'(underrun), 32'd1);
        rst = 1'b1;
        #1;
        check("underrun_cleared_by_rst", 32'(underrun), 32'd0);
        clk_wait(2);
        rst = 1'b0;
        clk_wait(2);

        // Full frame under one continuous cs_n
        load_pattern_a();
        push_expected(BYTES);
        pulse_start();
        check("busy_in_frame", 32'(busy), 32'd1);
        spi_frame(BYTES, 1'b1);
        wait_done(1);
        check("underrun_clean_frame", 32'(underrun), 32'd0);

        // Second start mid-frame is ignored
        push_expected(BYTES);
        pulse_start();
        spi_frame(5, 1'b1);
        pulse_start();
        check("busy_after_extra_start", 32'(busy), 32'd1);
        spi_frame(BYTES - 5, 1'b1);
        wait_done(2);
        check("addr_wrapped", 32'(bus.sram_addr), 32'd0);

        // cs_n raised after 3 bits of 0x5A, then the whole frame
        load_pattern_b();
        push_expected(BYTES);
        pulse_start();
        wait_ready();
        bus.spi_cs_n = 1'b0;
        clk_wait(2 * HALF);
        for (int i = 0; i < 3; i++) spi_bit();
        bus.spi_cs_n = 1'b1;
        clk_wait(16);
        check("next_byte_staged_after_abort", 32'(bus.MCU_RX_RDY), 32'd1);
        spi_frame(BYTES, 1'b1);
        wait_done(3);

        // Reset in the middle of a byte after 5 bytes
        load_pattern_a();
        push_expected(5);
        pulse_start();
        spi_frame(5, 1'b1);
        bus.spi_cs_n = 1'b0;
        clk_wait(2 * HALF);
        spi_bit();
        spi_bit();
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        bus.spi_cs_n = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(3);
        check("addr_after_rst", 32'(bus.sram_addr), 32'd0);
        push_expected(BYTES);
        pulse_start();
        spi_frame(BYTES, 1'b1);
        wait_done(4);
        check("underrun_after_restart", 32'(underrun), 32'd0);

        clk_wait(10);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
